// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: data path widths, memory-reference opcodes,
// the memory sequencer state encoding and the auto-index window.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_TAD = 3'd1,
    OP_ISZ = 3'd2,
    OP_DCA = 3'd3,
    OP_JMS = 3'd4,
    OP_JMP = 3'd5
  } mem_op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IND_RD   = 3'd1,
    S_IND_WAIT = 3'd2,
    S_AUTO_WR  = 3'd3,
    S_OP_RD    = 3'd4,
    S_OP_WAIT  = 3'd5,
    S_OP_WR    = 3'd6,
    S_DONE     = 3'd7
  } mseq_state_t;

  localparam logic [11:0] AUTOIDX_LO = 12'o0010;
  localparam logic [11:0] AUTOIDX_HI = 12'o0017;

  // First state once the effective address is final: reads for operand
  // fetches, straight to the write for stores, nothing at all for JMP.
  function automatic mseq_state_t direct_next(input mem_op_t op);
    case (op)
      OP_AND, OP_TAD, OP_ISZ: direct_next = S_OP_RD;
      OP_DCA, OP_JMS:         direct_next = S_OP_WR;
      default:                direct_next = S_DONE;
    endcase
  endfunction

endpackage

// File: rtl/exec_mem_sequencer.sv
// EXEC-side memory sequencer: turns one memory-reference instruction into
// its ordered read/write transactions (indirect, auto-index, ISZ RMW) and
// returns operand, final target address and skip flag.
module exec_mem_sequencer #(
  parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
  parameter int                    DATA_WIDTH = `DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] AUTOIDX_LO = pdp8_pkg::AUTOIDX_LO,
  parameter logic [ADDR_WIDTH-1:0] AUTOIDX_HI = pdp8_pkg::AUTOIDX_HI
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] ea_in,
  input  logic                  indirect,
  input  logic [DATA_WIDTH-1:0] ac_in,
  input  logic [ADDR_WIDTH-1:0] pc_ret,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0] target_addr,
  output logic                  skip,
  output logic                  exec_rd_req,
  output logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_wr_req,
  output logic [ADDR_WIDTH-1:0] exec_wr_addr,
  output logic [DATA_WIDTH-1:0] exec_wr_data
);
  import pdp8_pkg::*;

  mseq_state_t           r_state, w_next;
  mem_op_t               r_op;
  logic [ADDR_WIDTH-1:0] r_ea;        // current effective address
  logic [ADDR_WIDTH-1:0] r_ptr_addr;  // auto-index pointer location
  logic [DATA_WIDTH-1:0] r_auto;      // incremented pointer to write back
  logic [DATA_WIDTH-1:0] r_data;      // operand read (ISZ: already incremented)
  logic [DATA_WIDTH-1:0] r_ac;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_operand;   // held results between done pulses
  logic [ADDR_WIDTH-1:0] r_target;
  logic                  r_skip;

  logic [DATA_WIDTH-1:0] w_rd_inc;
  logic [ADDR_WIDTH-1:0] w_tgt;
  logic                  w_autoidx;
  logic                  w_has_opnd;
  logic                  w_skip;

  assign w_rd_inc   = exec_rd_data + DATA_WIDTH'(1);
  assign w_autoidx  = (r_ea >= AUTOIDX_LO) && (r_ea <= AUTOIDX_HI);
  assign w_has_opnd = (r_op == OP_AND) || (r_op == OP_TAD) || (r_op == OP_ISZ);
  assign w_tgt      = (r_op == OP_JMS) ? (r_ea + ADDR_WIDTH'(1)) : r_ea;
  assign w_skip     = (r_op == OP_ISZ) && (r_data == '0);

  // Results are live in DONE and then held by the r_ copies.
  assign operand     = (r_state == S_DONE && w_has_opnd) ? r_data : r_operand;
  assign target_addr = (r_state == S_DONE) ? w_tgt  : r_target;
  assign skip        = (r_state == S_DONE) ? w_skip : r_skip;
  assign busy        = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and Moore request decode (registered state/address/data only)
  always_comb begin
    w_next       = r_state;
    done         = 1'b0;
    exec_rd_req  = 1'b0;
    exec_rd_addr = '0;
    exec_wr_req  = 1'b0;
    exec_wr_addr = '0;
    exec_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = indirect ? S_IND_RD : direct_next(mem_op_t'(opcode));
      end
      S_IND_RD: begin
        exec_rd_req  = 1'b1;
        exec_rd_addr = r_ea;
        w_next       = S_IND_WAIT;
      end
      S_IND_WAIT: w_next = w_autoidx ? S_AUTO_WR : direct_next(r_op);
      S_AUTO_WR: begin
        exec_wr_req  = 1'b1;
        exec_wr_addr = r_ptr_addr;
        exec_wr_data = r_auto;
        w_next       = direct_next(r_op);
      end
      S_OP_RD: begin
        exec_rd_req  = 1'b1;
        exec_rd_addr = r_ea;
        w_next       = S_OP_WAIT;
      end
      S_OP_WAIT: w_next = (r_op == OP_ISZ) ? S_OP_WR : S_DONE;
      S_OP_WR: begin
        exec_wr_req  = 1'b1;
        exec_wr_addr = r_ea;
        case (r_op)
          OP_ISZ:  exec_wr_data = r_data;
          OP_JMS:  exec_wr_data = DATA_WIDTH'(r_pc);
          default: exec_wr_data = r_ac;
        endcase
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch the request, follow pointers, capture read data, hold results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= OP_AND;
      r_ea       <= '0;
      r_ptr_addr <= '0;
      r_auto     <= '0;
      r_data     <= '0;
      r_ac       <= '0;
      r_pc       <= '0;
      r_operand  <= '0;
      r_target   <= '0;
      r_skip     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= mem_op_t'(opcode);
            r_ea   <= ea_in;
            r_ac   <= ac_in;
            r_pc   <= pc_ret;
            r_skip <= 1'b0;
          end
        end
        S_IND_WAIT: begin
          r_ptr_addr <= r_ea;
          if (w_autoidx) begin
            r_auto <= w_rd_inc;
            r_ea   <= ADDR_WIDTH'(w_rd_inc);
          end else begin
            r_ea   <= ADDR_WIDTH'(exec_rd_data);
          end
        end
        S_OP_WAIT: r_data <= (r_op == OP_ISZ) ? w_rd_inc : exec_rd_data;
        S_DONE: begin
          if (w_has_opnd) r_operand <= r_data;
          r_target <= w_tgt;
          r_skip   <= w_skip;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_sequencer.sv
// Directed bench for exec_mem_sequencer with an array memory responder and
// a scoreboard of expected memory transactions (kind/addr/data/cycle).
module tb_exec_mem_sequencer;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [11:0] data;
    logic [7:0]  rel;
  } xact_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [11:0] ea_in = '0;
  logic        indirect = 1'b0;
  logic [11:0] ac_in = '0;
  logic [11:0] pc_ret = '0;
  logic        busy, done, skip;
  logic [11:0] operand, target_addr;
  logic        exec_rd_req, exec_wr_req;
  logic [11:0] exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic [11:0] exec_rd_data = '0;

  logic [11:0] mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0, pl_data = '0;

  int    checks = 0, errors = 0;
  int    cyc = 0, c0 = 0, done_cnt = 0;
  xact_t exp_q[$];
  xact_t obs_x, exp_x;

  exec_mem_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .ea_in(ea_in),
    .indirect(indirect), .ac_in(ac_in), .pc_ret(pc_ret), .busy(busy), .done(done),
    .operand(operand), .target_addr(target_addr), .skip(skip),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: 1-cycle registered read, bench preload port
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (exec_wr_req) mem[exec_wr_addr] <= exec_wr_data;
    if (exec_rd_req) exec_rd_data <= mem[exec_rd_addr];
  end

  // Monitor: every request cycle must match the next scoreboard entry
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (exec_rd_req || exec_wr_req) begin
      checks++;
      assert (!(exec_rd_req && exec_wr_req)) else begin
        errors++;
        $error("FAIL rd_wr_overlap observed both=1 expected one");
      end
      obs_x.wr   = exec_wr_req;
      obs_x.addr = exec_wr_req ? exec_wr_addr : exec_rd_addr;
      obs_x.data = exec_wr_req ? exec_wr_data : 12'o0;
      obs_x.rel  = 8'(cyc - c0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_req observed wr=%0b addr=%o data=%o rel=%0d expected none",
               obs_x.wr, obs_x.addr, obs_x.data, obs_x.rel);
      end else begin
        exp_x = exp_q.pop_front();
        assert (obs_x === exp_x) else begin
          errors++;
          $error("FAIL mem_xact observed wr=%0b addr=%o data=%o rel=%0d expected wr=%0b addr=%o data=%o rel=%0d",
                 obs_x.wr, obs_x.addr, obs_x.data, obs_x.rel,
                 exp_x.wr, exp_x.addr, exp_x.data, exp_x.rel);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic push(input logic wr, input logic [11:0] a, input logic [11:0] d, input int rel);
    xact_t x;
    x.wr = wr; x.addr = a; x.data = d; x.rel = 8'(rel);
    exp_q.push_back(x);
  endtask

  // Issue one instruction, wait (bounded) for done, check latency and results
  task automatic do_op(input string name, input logic [2:0] op, input logic [11:0] ea,
                       input logic ind, input logic [11:0] ac, input logic [11:0] pc,
                       input int lat, input logic chk_opnd, input logic [11:0] e_opnd,
                       input logic [11:0] e_tgt, input logic e_skip, input logic poke);
    bit got;
    @(negedge clk);
    opcode = op; ea_in = ea; indirect = ind; ac_in = ac; pc_ret = pc;
    start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_skip_clear"}, {31'd0, skip}, 32'd0);
    if (poke && !done) begin
      // Second request while busy: a JMP that would finish immediately if taken
      opcode = 3'd5; ea_in = 12'o0777; indirect = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({name, "_latency"}, 32'(cyc - c0), 32'(lat));
      if (chk_opnd) chk({name, "_operand"}, {20'd0, operand}, {20'd0, e_opnd});
      chk({name, "_target"}, {20'd0, target_addr}, {20'd0, e_tgt});
      chk({name, "_skip"}, {31'd0, skip}, {31'd0, e_skip});
      @(negedge clk);
      chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
      if (chk_opnd) chk({name, "_operand_hold"}, {20'd0, operand}, {20'd0, e_opnd});
      chk({name, "_target_hold"}, {20'd0, target_addr}, {20'd0, e_tgt});
    end
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int dc;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {27'd0, busy, done, skip, exec_rd_req, exec_wr_req}, 32'd0);
    chk("reset_operand", {20'd0, operand}, 32'd0);
    chk("reset_target", {20'd0, target_addr}, 32'd0);
    reset = 1'b0;

    preload(12'o0200, 12'o1234);
    preload(12'o0050, 12'o3000);
    preload(12'o0010, 12'o7777);
    preload(12'o0000, 12'o0042);
    preload(12'o0300, 12'o7777);
    preload(12'o0301, 12'o0005);

    // TAD direct
    push(1'b0, 12'o0200, 12'o0, 1);
    do_op("tad_dir", 3'd1, 12'o0200, 1'b0, 12'o0, 12'o0, 3, 1'b1, 12'o1234, 12'o0200, 1'b0, 1'b0);

    // DCA indirect through a non-auto-index pointer
    push(1'b0, 12'o0050, 12'o0, 1);
    push(1'b1, 12'o3000, 12'o0777, 3);
    do_op("dca_ind", 3'd3, 12'o0050, 1'b1, 12'o0777, 12'o0, 4, 1'b0, 12'o0, 12'o3000, 1'b0, 1'b0);
    chk("dca_ptr_unchanged", {20'd0, mem[12'o0050]}, {20'd0, 12'o3000});
    chk("dca_stored", {20'd0, mem[12'o3000]}, {20'd0, 12'o0777});

    // TAD auto-index, pointer wraps 7777 -> 0000
    push(1'b0, 12'o0010, 12'o0, 1);
    push(1'b1, 12'o0010, 12'o0000, 3);
    push(1'b0, 12'o0000, 12'o0, 4);
    do_op("tad_auto", 3'd1, 12'o0010, 1'b1, 12'o0, 12'o0, 6, 1'b1, 12'o0042, 12'o0000, 1'b0, 1'b0);
    chk("auto_ptr_written", {20'd0, mem[12'o0010]}, 32'd0);

    // ISZ direct: overflow to zero skips, ordinary increment does not
    push(1'b0, 12'o0300, 12'o0, 1);
    push(1'b1, 12'o0300, 12'o0000, 3);
    do_op("isz_wrap", 3'd2, 12'o0300, 1'b0, 12'o0, 12'o0, 4, 1'b1, 12'o0000, 12'o0300, 1'b1, 1'b0);
    push(1'b0, 12'o0301, 12'o0, 1);
    push(1'b1, 12'o0301, 12'o0006, 3);
    do_op("isz_plain", 3'd2, 12'o0301, 1'b0, 12'o0, 12'o0, 4, 1'b1, 12'o0006, 12'o0301, 1'b0, 1'b0);
    chk("isz_mem", {20'd0, mem[12'o0301]}, {20'd0, 12'o0006});

    // JMS direct at the top of memory, return target wraps
    push(1'b1, 12'o7777, 12'o0101, 1);
    do_op("jms_wrap", 3'd4, 12'o7777, 1'b0, 12'o0, 12'o0101, 2, 1'b0, 12'o0, 12'o0000, 1'b0, 1'b0);

    // JMP direct: no memory traffic
    do_op("jmp_dir", 3'd5, 12'o0400, 1'b0, 12'o0, 12'o0, 1, 1'b0, 12'o0, 12'o0400, 1'b0, 1'b0);

    // start while busy is dropped
    dc = done_cnt;
    push(1'b0, 12'o0200, 12'o0, 1);
    do_op("busy_ignore", 3'd0, 12'o0200, 1'b0, 12'o0, 12'o0, 3, 1'b1, 12'o1234, 12'o0200, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_ignore_done_cnt", 32'(done_cnt - dc), 32'd1);

    // Reset in OP_WAIT of ISZ aborts before the write
    dc = done_cnt;
    push(1'b0, 12'o0300, 12'o0, 1);
    @(negedge clk);
    opcode = 3'd2; ea_in = 12'o0300; indirect = 1'b0; start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_in_op_wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_abort_ctrl", {29'd0, busy, done, exec_wr_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_abort_no_done", 32'(done_cnt - dc), 32'd0);
    chk("rst_abort_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rst_abort_mem", {20'd0, mem[12'o0300]}, 32'd0);
    chk("rst_abort_operand", {20'd0, operand}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_mem_sequencer.md
Name: exec_mem_sequencer

Overview:
- EXEC-side initiator for the memory read/write request interface: converts one memory-reference instruction (AND, TAD, ISZ, DCA, JMS, JMP) into the ordered sequence of exec_rd_req/exec_wr_req transactions.
- Handles indirect addressing, auto-index pointer increment (locations 0010–0017 octal) and the ISZ read-modify-write.
- Sits between EXEC decode/ALU and the memory responder. Returns the operand, the final target address and the skip flag to EXEC.

Parameters:
- ADDR_WIDTH, 12, address width (`ADDR_WIDTH).
- DATA_WIDTH, 12, data width (`DATA_WIDTH).
- AUTOIDX_LO, 12'o0010, first auto-index location.
- AUTOIDX_HI, 12'o0017, last auto-index location.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  3  pdp8_pkg op: AND=0 TAD=1 ISZ=2 DCA=3 JMS=4 JMP=5.
- ea_in  in  ADDR_WIDTH  direct effective address from IFD.
- indirect  in  1  I bit.
- ac_in  in  DATA_WIDTH  accumulator; DCA store data.
- pc_ret  in  ADDR_WIDTH  JMS return address (PC+1).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- operand  out  DATA_WIDTH  AND/TAD read data, or ISZ incremented value; valid with done.
- target_addr  out  ADDR_WIDTH  final EA (JMP), or EA+1 (JMS); valid with done.
- skip  out  1  ISZ result == 0; valid with done.
- exec_rd_req  out  1  memory read request.
- exec_rd_addr  out  ADDR_WIDTH  read address.
- exec_rd_data  in  DATA_WIDTH  read data; registered by the responder, valid the cycle after exec_rd_req.
- exec_wr_req  out  1  memory write request.
- exec_wr_addr  out  ADDR_WIDTH  write address.
- exec_wr_data  out  DATA_WIDTH  write data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; internal ea/data registers 0.
  - Reset asserted mid-operation aborts it: no done pulse, req lines low from the next cycle.
- States: IDLE, IND_RD, IND_WAIT, AUTO_WR, OP_RD, OP_WAIT, OP_WR, DONE.
  - Request outputs decode from registered state and registered address/data only (Moore); no combinational path from inputs.
- IDLE:
  - On start, latch opcode/ea_in/ac_in/pc_ret.
  - indirect=1 → IND_RD. Otherwise AND/TAD/ISZ → OP_RD; DCA/JMS → OP_WR; JMP → DONE.
- IND_RD: rd_req=1, rd_addr=ea → IND_WAIT.
- IND_WAIT: capture ptr=exec_rd_data.
  - If ea in AUTOIDX_LO..AUTOIDX_HI: ptr+1 (mod 2^12), ea←ptr+1 → AUTO_WR.
  - Else ea←ptr and branch per opcode as from IDLE (direct case).
- AUTO_WR: wr_req=1, wr_addr=original pointer location, wr_data=ptr+1 → per-opcode branch.
- OP_RD: rd_req=1, rd_addr=ea → OP_WAIT.
- OP_WAIT: capture data.
  - AND/TAD → DONE with operand=data.
  - ISZ → data+1 (wraps 7777→0000) → OP_WR.
- OP_WR: wr_req=1, wr_addr=ea.
  - wr_data = incremented value (ISZ), ac (DCA), or pc_ret (JMS).
  - → DONE.
- DONE: done=1, outputs valid for this cycle → IDLE.
  - target_addr = ea for JMP; ea+1 for JMS (7777→0000); ea otherwise.
  - skip=1 only for ISZ with result 0.
- Latency from the start cycle to the done cycle:
  - JMP direct: 1.
  - DCA/JMS direct: 2.
  - AND/TAD direct: 3.
  - ISZ direct: 4.
  - Indirect adds 2; auto-index adds 1 more.
- exec_rd_req and exec_wr_req are never high in the same cycle. Each is high for exactly one cycle per transaction.
- start while busy is ignored; no queuing.
- operand/target_addr/skip hold their last values between done pulses; skip clears on the next start.

Decomposition:
- pdp8_pkg holds: opcode enum (mem_op_t), state enum (mseq_state_t), AUTOIDX_LO/HI constants, and the existing `ADDR_WIDTH`/`DATA_WIDTH` defines.
- No sub-module: the FSM plus one incrementer and a small mux fit in a single module.
- The bench uses a deterministic array memory model (same port set and 1-cycle read latency as the existing memory responder), not random data.

Test Plan:
- TAD direct, ea=0200, mem[0200]=1234 → rd_req cycle 1 addr 0200; done cycle 3, operand=1234; no wr_req.
- DCA indirect, ea=0050, mem[0050]=3000, ac=0777:
  - rd at 0050, then wr_req addr 3000 data 0777.
  - done at cycle 4; mem[0050] unchanged.
- TAD auto-index, ea=0010, mem[0010]=7777, mem[0000]=0042:
  - wr 0010←0000, then rd 0000.
  - operand=0042; done at cycle 6.
- ISZ direct, mem[0300]=7777 → wr 0300←0000, skip=1, done at cycle 4. Repeat with 0005 → writes 0006, skip=0.
- JMS direct, ea=7777, pc_ret=0101 → wr 7777←0101; target_addr=0000 (wrap); done at cycle 2. JMP direct ea=0400 → done at cycle 1, target 0400, no memory traffic.
- Reset asserted in OP_WAIT of ISZ → no wr_req, no done, busy=0 next cycle. start pulsed while busy → ignored; transaction count unchanged.
